// File: rtl/uart_bus_engine.sv
// UART-to-parallel-bus bridge. Decodes CMD/LEN/ADDR/DATA frames from a byte
// stream, runs bus reads/writes with timeout, and returns read data plus a status byte.
module uart_bus_engine #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          new_rx_data,
    output logic [7:0]    tx_data,
    output logic          new_tx_data,
    input  logic          tx_busy,
    output logic [AW-1:0] int_address,
    output logic [DW-1:0] int_wr_data,
    output logic          int_req,
    output logic          int_write,
    input  logic          int_ack,
    input  logic [DW-1:0] int_rd_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_BUS   = 3'd4;
    localparam logic [2:0] S_TXRD  = 3'd5;
    localparam logic [2:0] S_TXACK = 3'd6;

    localparam logic [2:0]  ADDR_LAST = 3'(AW / 8 - 1);
    localparam logic [2:0]  DATA_LAST = 3'(DW / 8 - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [7:0]  ACK_OK    = 8'h5A;
    localparam logic [7:0]  ACK_ERR   = 8'hEE;

    logic [2:0]    state;
    logic          cmd_write;
    logic          no_inc;
    logic [8:0]    word_cnt;
    logic [2:0]    byte_cnt;
    logic [DW-1:0] rd_buf;
    logic [15:0]   tmo_cnt;
    logic [7:0]    status;

    logic          tx_ready;
    logic [8:0]    word_left;
    logic          cmd_valid;

    // A transmit slot needs an idle UART and a one-cycle gap after the last pulse.
    always_comb begin
        tx_ready  = !tx_busy && !new_tx_data;
        word_left = word_cnt - 9'd1;
        cmd_valid = (rx_data[7:4] == 4'h1) || (rx_data[7:4] == 4'h2);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below reads the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cmd_write   <= 1'b0;
            no_inc      <= 1'b0;
            word_cnt    <= 9'd0;
            byte_cnt    <= 3'd0;
            rd_buf      <= '0;
            tmo_cnt     <= 16'd0;
            status      <= 8'h00;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
            int_address <= '0;
            int_wr_data <= '0;
            int_req     <= 1'b0;
            int_write   <= 1'b0;
        end else begin
            new_tx_data <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (new_rx_data && cmd_valid) begin
                        cmd_write <= (rx_data[7:4] == 4'h1);
                        no_inc    <= rx_data[0];
                        state     <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (new_rx_data) begin
                        word_cnt <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        byte_cnt <= ADDR_LAST;
                        state    <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (new_rx_data) begin
                        int_address <= AW'({int_address, rx_data});
                        if (byte_cnt == 3'd0) begin
                            byte_cnt <= DATA_LAST;
                            state    <= cmd_write ? S_WDATA : S_BUS;
                        end else begin
                            byte_cnt <= byte_cnt - 3'd1;
                        end
                    end
                end

                S_WDATA: begin
                    if (new_rx_data) begin
                        int_wr_data <= DW'({int_wr_data, rx_data});
                        if (byte_cnt == 3'd0) begin
                            state <= S_BUS;
                        end else begin
                            byte_cnt <= byte_cnt - 3'd1;
                        end
                    end
                end

                S_BUS: begin
                    if (!int_req) begin
                        int_req   <= 1'b1;
                        int_write <= cmd_write;
                        tmo_cnt   <= 16'd0;
                    end else if (int_ack) begin
                        int_req   <= 1'b0;
                        int_write <= 1'b0;
                        word_cnt  <= word_left;
                        byte_cnt  <= DATA_LAST;
                        if (!no_inc) begin
                            int_address <= int_address + AW'(1);
                        end
                        if (!cmd_write) begin
                            rd_buf <= int_rd_data;
                            state  <= S_TXRD;
                        end else if (word_left == 9'd0) begin
                            status <= ACK_OK;
                            state  <= S_TXACK;
                        end else begin
                            state <= S_WDATA;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Abandon the rest of the frame; leftover host bytes reparse as commands.
                        int_req   <= 1'b0;
                        int_write <= 1'b0;
                        word_cnt  <= 9'd0;
                        status    <= ACK_ERR;
                        state     <= S_TXACK;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                S_TXRD: begin
                    if (tx_ready) begin
                        tx_data     <= rd_buf[DW-1 -: 8];
                        new_tx_data <= 1'b1;
                        rd_buf      <= rd_buf << 8;
                        if (byte_cnt != 3'd0) begin
                            byte_cnt <= byte_cnt - 3'd1;
                        end else if (word_cnt == 9'd0) begin
                            status <= ACK_OK;
                            state  <= S_TXACK;
                        end else begin
                            state <= S_BUS;
                        end
                    end
                end

                S_TXACK: begin
                    if (tx_ready) begin
                        tx_data     <= status;
                        new_tx_data <= 1'b1;
                        state       <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_bus_engine.md
UART_BUS_ENGINE -- requirements
Module: uart_bus_engine

Interface
REQ-001 The block SHALL have parameter AW, default 16, giving the bus address width in bits; legal values are 8, 16, 24 and 32.
REQ-002 The block SHALL have parameter DW, default 8, giving the bus data width in bits; legal values are 8, 16 and 32.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles to wait for int_ack (1..65535).
REQ-004 Port clock, input, 1: single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port rx_data, input, 8: received byte from the uart.
REQ-007 Port new_rx_data, input, 1: one-cycle pulse qualifying rx_data.
REQ-008 Port tx_data, output, 8: byte to transmit.
REQ-009 Port new_tx_data, output, 1: one-cycle pulse qualifying tx_data.
REQ-010 Port tx_busy, input, 1: transmitter busy.
REQ-011 Port int_address, output, AW: bus address.
REQ-012 Port int_wr_data, output, DW: bus write data.
REQ-013 Port int_req, output, 1: bus request, held until acknowledged.
REQ-014 Port int_write, output, 1: 1 = write, 0 = read; valid while int_req is high.
REQ-015 Port int_ack, input, 1: completes the transaction in the cycle it is sampled high with int_req.
REQ-016 Port int_rd_data, input, DW: read data, valid in the int_ack cycle.

Function
REQ-017 Frame format SHALL be: CMD byte, LEN byte, AW/8 address bytes MSB first, then for writes LEN words of DW/8 bytes each, MSB first.
REQ-018 CMD[7:4] SHALL decode as 0x1 = write and 0x2 = read; CMD[0] = 1 SHALL disable address auto-increment; any other CMD[7:4] SHALL be discarded with the FSM remaining in IDLE.
REQ-019 A LEN value of 0 SHALL mean 256 words; the word counter SHALL be 9 bits wide.
REQ-020 The FSM SHALL have states IDLE, LEN, ADDR, WDATA, BUS, TXRD, TXACK, advancing on new_rx_data in LEN, ADDR and WDATA.
REQ-021 Write flow: WDATA SHALL assemble a word, then BUS asserts int_req=1, int_write=1 with int_wr_data stable until int_ack; the next word returns to WDATA, the last word goes to TXACK.
REQ-022 Read flow: after ADDR, BUS SHALL assert int_req=1, int_write=0; on int_ack, int_rd_data is captured and TXRD sends DW/8 bytes MSB first; this repeats LEN times, then TXACK.
REQ-023 int_req SHALL rise the cycle after BUS is entered and fall the cycle after int_ack.
REQ-024 After each acknowledged transaction, int_address SHALL increment by 1 (unless CMD[0]=1), wrapping modulo 2^AW.
REQ-025 new_tx_data SHALL pulse only when tx_busy=0 and no pulse occurred in the previous cycle.
REQ-026 TXACK SHALL send 0x5A on success.
REQ-027 If int_ack is not seen within TIMEOUT cycles of int_req rising, int_req SHALL drop, remaining words SHALL be abandoned, TXACK SHALL send 0xEE, and the FSM SHALL return to IDLE.
REQ-028 During a write timeout, unused frame bytes received afterwards SHALL be parsed as new CMD bytes; the host is responsible for resync.
REQ-029 new_rx_data arriving in BUS, TXRD or TXACK SHALL be dropped.
REQ-030 int_ack arriving while int_req=0 SHALL be ignored.

Reset
REQ-031 While reset=0, the block SHALL enter IDLE with int_req=0, int_write=0, new_tx_data=0, tx_data=0, int_address=0, int_wr_data=0, word counter=0 and timeout counter=0, asynchronously.
REQ-032 Reset asserted mid-transaction SHALL drop int_req immediately, with no ack byte sent.

Verification
REQ-033 Default parameters, rx 10 01 12 34 AB, int_ack after 3 cycles -> one write: addr 0x1234, data 0xAB, then tx 0x5A.
REQ-034 Rx 20 03 00 FE, rd_data 11/22/33 -> reads at 0x00FE, 0x00FF, 0x0100; tx 11 22 33 5A.
REQ-035 AW=16, DW=16, rx 21 02 FF FF -> both reads at 0xFFFF (no increment); each word is sent as 2 bytes MSB first.
REQ-036 int_ack is never asserted, TIMEOUT=255 -> int_req falls 255 cycles after rising; tx 0xEE; FSM back in IDLE.
REQ-037 Rx 7F, then a valid write frame -> 7F is ignored and the write completes normally.
REQ-038 reset=0 during BUS with int_req=1 -> all outputs reach their REQ-031 values without a clock edge.
